// File: rtl/hyperbus_tf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hyperbus_tf_arbiter
// Brief    : Round-robin arbiter that lends a single HyperBus PHY transfer
//            port to NumReq requesters, one outstanding transfer at a time,
//            with a configurable read-write-recovery gap between transfers.
// Revision : 1.0 - initial release
// ============================================================================
module hyperbus_tf_arbiter #(
  parameter int NumReq  = 4,
  parameter int TfWidth = 50,
  parameter int IdWidth = $clog2(NumReq)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_valid_i,
  output logic [NumReq-1:0]         req_ready_o,
  input  logic [NumReq*TfWidth-1:0] req_tf_i,
  output logic                      tf_valid_o,
  input  logic                      tf_ready_i,
  output logic [TfWidth-1:0]        tf_o,
  output logic [IdWidth-1:0]        tf_id_o,
  input  logic                      done_i,
  input  logic [3:0]                cfg_t_rwr_i,
  output logic                      busy_o,
  output logic                      err_o
);

  // Burst length sits right below the write flag at the top of hyper_tf_t.
  localparam int c_BURST_W   = 15;
  localparam int c_BURST_MSB = TfWidth - 2;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_ISSUE   = 2'd1;
  localparam logic [1:0] c_ST_BUSY    = 2'd2;
  localparam logic [1:0] c_ST_RECOVER = 2'd3;

  logic [1:0]           state_q,  state_d;
  logic [IdWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TfWidth-1:0]   tf_q,     tf_d;
  logic [IdWidth-1:0]   tf_id_q,  tf_id_d;
  logic [3:0]           cnt_q,    cnt_d;
  logic                 err_q,    err_d;

  logic                 w_any_valid;
  logic [IdWidth-1:0]   w_winner;
  logic [TfWidth-1:0]   w_winner_tf;
  logic [c_BURST_W-1:0] w_winner_burst;
  logic [IdWidth-1:0]   w_ptr_next;

  assign w_any_valid    = |req_valid_i;
  assign w_winner_tf    = req_tf_i[int'(w_winner)*TfWidth +: TfWidth];
  assign w_winner_burst = w_winner_tf[c_BURST_MSB -: c_BURST_W];
  assign w_ptr_next     = (w_winner == IdWidth'(NumReq - 1)) ? '0 : w_winner + IdWidth'(1);

  // Winner search: scan from rr_ptr upward with wrap; the lowest offset wins,
  // so iterating from the far end lets the nearest valid requester overwrite.
  always_comb begin
    int                 j;
    logic [IdWidth-1:0] idx;
    j        = 0;
    idx      = '0;
    w_winner = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NumReq) j = j - NumReq;
      idx = IdWidth'(j);
      if (req_valid_i[idx]) w_winner = idx;
    end
  end

  // State and datapath registers; reset abandons any in-flight transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= c_ST_IDLE;
      rr_ptr_q <= '0;
      tf_q     <= '0;
      tf_id_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      tf_q     <= tf_d;
      tf_id_q  <= tf_id_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: grant in IDLE, hand off in ISSUE, wait in BUSY, gap in RECOVER.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    tf_d     = tf_q;
    tf_id_d  = tf_id_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (w_any_valid) begin
          rr_ptr_d = w_ptr_next;
          if (w_winner_burst != '0) begin
            tf_d    = w_winner_tf;
            tf_id_d = w_winner;
            state_d = c_ST_ISSUE;
          end else begin
            // Zero-length burst: consume the request but never forward it.
            err_d = 1'b1;
          end
        end
      end
      c_ST_ISSUE: begin
        if (tf_ready_i) state_d = c_ST_BUSY;
      end
      c_ST_BUSY: begin
        if (done_i) begin
          if (cfg_t_rwr_i == 4'd0) begin
            state_d = c_ST_IDLE;
          end else begin
            // Recovery length is captured here so later cfg changes are ignored.
            cnt_d   = cfg_t_rwr_i;
            state_d = c_ST_RECOVER;
          end
        end
      end
      default: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = 4'd0;
          state_d = c_ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  // Outputs: ready is gated by reset so it reads zero while rst_i is held.
  always_comb begin
    req_ready_o = '0;
    if (state_q == c_ST_IDLE && w_any_valid && !rst_i) begin
      req_ready_o = NumReq'(1) << w_winner;
    end
    tf_valid_o = (state_q == c_ST_ISSUE);
    busy_o     = (state_q != c_ST_IDLE);
    tf_o       = tf_q;
    tf_id_o    = tf_id_q;
    err_o      = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_hyperbus_tf_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyperbus_tf_arbiter
// Brief    : Directed self-checking bench for hyperbus_tf_arbiter (4 requesters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyperbus_tf_arbiter;

  localparam int N  = 4;
  localparam int TW = 50;
  localparam int IW = 2;

  logic            clk_i;
  logic            rst_i;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*TW-1:0] req_tf_i;
  logic            tf_valid_o;
  logic            tf_ready_i;
  logic [TW-1:0]   tf_o;
  logic [IW-1:0]   tf_id_o;
  logic            done_i;
  logic [3:0]      cfg_t_rwr_i;
  logic            busy_o;
  logic            err_o;

  logic [TW-1:0]   tfs [N];
  int              checks;
  int              errors;

  assign req_tf_i = {tfs[3], tfs[2], tfs[1], tfs[0]};

  hyperbus_tf_arbiter #(.NumReq(N), .TfWidth(TW), .IdWidth(IW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_tf_i    (req_tf_i),
    .tf_valid_o  (tf_valid_o),
    .tf_ready_i  (tf_ready_i),
    .tf_o        (tf_o),
    .tf_id_o     (tf_id_o),
    .done_i      (done_i),
    .cfg_t_rwr_i (cfg_t_rwr_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [TW-1:0] mktf(input logic wr, input logic [14:0] burst, input logic [31:0] addr);
    return {wr, burst, 1'b0, 1'b0, addr};
  endfunction

  task automatic nc();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    req_valid_i = '0; tf_ready_i = 1'b0; done_i = 1'b0; cfg_t_rwr_i = 4'd0;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    req_valid_i = 4'b1111;
    #1;
    checks++; if (req_ready_o !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready_o); end
    checks++; if ({tf_valid_o, busy_o, err_o} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {tf_valid_o, busy_o, err_o}); end
    checks++; if (tf_o !== '0 || tf_id_o !== '0) begin errors++; $display("FAIL reset_tf got %h/%0d exp 0/0", tf_o, tf_id_o); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    tfs[2] = mktf(1'b0, 15'd16, 32'h100);
    nc(); req_valid_i = 4'b0100; #1;
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL single_ready got %b exp 0100", req_ready_o); end
    checks++; if (tf_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid0 got %b exp 0", tf_valid_o); end
    nc(); req_valid_i = '0; tf_ready_i = 1'b1; #1;
    checks++; if (tf_valid_o !== 1'b1 || tf_id_o !== 2'd2) begin errors++; $display("FAIL single_issue got v=%b id=%0d exp v=1 id=2", tf_valid_o, tf_id_o); end
    checks++; if (tf_o !== mktf(1'b0, 15'd16, 32'h100)) begin errors++; $display("FAIL single_tf got %h", tf_o); end
    nc(); tf_ready_i = 1'b0; done_i = 1'b1; #1;
    checks++; if (tf_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL single_busy got v=%b b=%b exp v=0 b=1", tf_valid_o, busy_o); end
    nc(); done_i = 1'b0; #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b exp 0", busy_o); end
  endtask

  task automatic test_round_robin();
    int exp_id;
    do_reset();
    for (int k = 0; k < N; k++) tfs[k] = mktf(1'b1, 15'(k + 1), 32'(k * 16));
    for (int g = 0; g < 6; g++) begin
      exp_id = g % N;
      nc(); req_valid_i = 4'b1111; tf_ready_i = 1'b1; done_i = 1'b0; #1;
      checks++; if (req_ready_o !== 4'(1 << exp_id)) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", g, req_ready_o, 4'(1 << exp_id)); end
      nc(); #1;
      checks++; if (tf_valid_o !== 1'b1 || tf_id_o !== 2'(exp_id)) begin errors++; $display("FAIL rr_issue%0d got v=%b id=%0d exp v=1 id=%0d", g, tf_valid_o, tf_id_o, exp_id); end
      checks++; if (tf_o !== tfs[exp_id]) begin errors++; $display("FAIL rr_tf%0d got %h exp %h", g, tf_o, tfs[exp_id]); end
      nc(); #1;
      nc(); done_i = 1'b1; #1;
    end
    nc(); done_i = 1'b0; req_valid_i = '0; tf_ready_i = 1'b0;
  endtask

  task automatic test_recovery();
    do_reset();
    tfs[3] = mktf(1'b0, 15'd4, 32'h300);
    nc(); req_valid_i = 4'b1000; #1;
    checks++; if (req_ready_o !== 4'b1000) begin errors++; $display("FAIL rec_grant got %b exp 1000", req_ready_o); end
    nc(); tf_ready_i = 1'b1; #1;
    nc(); tf_ready_i = 1'b0; done_i = 1'b1; cfg_t_rwr_i = 4'd3; #1;
    for (int r = 0; r < 3; r++) begin
      nc(); done_i = 1'b0; cfg_t_rwr_i = 4'd0; #1;
      checks++; if (busy_o !== 1'b1 || req_ready_o !== 4'b0000 || tf_valid_o !== 1'b0) begin errors++; $display("FAIL rec_gap%0d got b=%b r=%b v=%b exp b=1 r=0000 v=0", r, busy_o, req_ready_o, tf_valid_o); end
    end
    nc(); #1;
    checks++; if (req_ready_o !== 4'b1000 || busy_o !== 1'b0) begin errors++; $display("FAIL rec_regrant got r=%b b=%b exp r=1000 b=0", req_ready_o, busy_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    tfs[0] = mktf(1'b1, 15'd5, 32'hABC);
    nc(); req_valid_i = 4'b0001; #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL bp_grant got %b exp 0001", req_ready_o); end
    for (int k = 0; k < 5; k++) begin
      nc(); req_valid_i = 4'b1110; tf_ready_i = 1'b0; done_i = (k == 2); #1;
      checks++; if (tf_valid_o !== 1'b1 || tf_id_o !== 2'd0 || req_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_hold%0d got v=%b id=%0d r=%b exp v=1 id=0 r=0000", k, tf_valid_o, tf_id_o, req_ready_o); end
      checks++; if (tf_o !== mktf(1'b1, 15'd5, 32'hABC)) begin errors++; $display("FAIL bp_tf%0d got %h", k, tf_o); end
    end
    nc(); tf_ready_i = 1'b1; done_i = 1'b1; #1;
    nc(); tf_ready_i = 1'b0; done_i = 1'b0; #1;
    checks++; if (busy_o !== 1'b1 || tf_valid_o !== 1'b0) begin errors++; $display("FAIL bp_busy got b=%b v=%b exp b=1 v=0", busy_o, tf_valid_o); end
    nc(); done_i = 1'b1; #1;
    checks++; if (busy_o !== 1'b1 || req_ready_o !== 4'b0000) begin errors++; $display("FAIL bp_done_ign got b=%b r=%b exp b=1 r=0000", busy_o, req_ready_o); end
    nc(); done_i = 1'b0; #1;
    checks++; if (req_ready_o !== 4'b0010) begin errors++; $display("FAIL bp_next got %b exp 0010", req_ready_o); end
  endtask

  task automatic test_zero_burst();
    do_reset();
    tfs[0] = mktf(1'b0, 15'd2, 32'h0);
    tfs[1] = mktf(1'b0, 15'd0, 32'h55);
    nc(); req_valid_i = 4'b0010; #1;
    checks++; if (req_ready_o !== 4'b0010 || err_o !== 1'b0) begin errors++; $display("FAIL zb_grant got r=%b e=%b exp r=0010 e=0", req_ready_o, err_o); end
    nc(); req_valid_i = '0; #1;
    checks++; if (err_o !== 1'b1 || tf_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL zb_err got e=%b v=%b b=%b exp e=1 v=0 b=0", err_o, tf_valid_o, busy_o); end
    nc(); #1;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL zb_pulse got %b exp 0", err_o); end
    nc(); req_valid_i = 4'b0011; #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL zb_ptr got %b exp 0001", req_ready_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < N; k++) tfs[k] = mktf(1'b0, 15'd8, 32'(k));
    nc(); req_valid_i = 4'b0100; #1;
    checks++; if (req_ready_o !== 4'b0100) begin errors++; $display("FAIL rm_grant got %b exp 0100", req_ready_o); end
    nc(); req_valid_i = 4'b1111; tf_ready_i = 1'b1; #1;
    nc(); tf_ready_i = 1'b0; #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL rm_busy got %b exp 1", busy_o); end
    #2 rst_i = 1'b1;
    #1;
    checks++; if ({tf_valid_o, busy_o, err_o} !== 3'b000 || req_ready_o !== 4'b0000) begin errors++; $display("FAIL rm_async got v/b/e=%b r=%b exp 000/0000", {tf_valid_o, busy_o, err_o}, req_ready_o); end
    checks++; if (tf_o !== '0 || tf_id_o !== 2'd0) begin errors++; $display("FAIL rm_tf got %h/%0d exp 0/0", tf_o, tf_id_o); end
    nc(); rst_i = 1'b0; #1;
    checks++; if (req_ready_o !== 4'b0001) begin errors++; $display("FAIL rm_restart got %b exp 0001", req_ready_o); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_i = 1'b1; req_valid_i = '0; tf_ready_i = 1'b0; done_i = 1'b0; cfg_t_rwr_i = 4'd0;
    for (int k = 0; k < N; k++) tfs[k] = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_recovery();
    test_backpressure();
    test_zero_burst();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hyperbus_tf_arbiter.md
Name: hyperbus_tf_arbiter

Overview:
- Shares one HyperBus PHY transfer port between NumReq upstream requesters. Each requester is an AXI front-end or a register/config master.
- Each grant is round-robin.
- Exactly one transfer is outstanding at a time. The block holds the PHY until it signals completion.
- After each transfer it inserts the configured read-write-recovery gap before the next grant.
- Sits between the request front-ends and the PHY transfer queue.

Parameters:
- NumReq, 4, number of requesters (2..16).
- TfWidth, 50, width of one packed hyper_tf_t: write(1), burst(15), burst_type(1), address_space(1), address(32), MSB first.
- IdWidth, $clog2(NumReq), width of the granted requester index.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  NumReq  per-requester transfer valid
- req_ready_o  out  NumReq  per-requester accept; at most one bit high per cycle
- req_tf_i  in  NumReq*TfWidth  per-requester hyper_tf_t; requester k occupies bits [k*TfWidth +: TfWidth]
- tf_valid_o  out  1  transfer to PHY valid
- tf_ready_i  in  1  PHY accepts transfer
- tf_o  out  TfWidth  registered granted transfer
- tf_id_o  out  IdWidth  index of granted requester
- done_i  in  1  single-cycle pulse from PHY: current transfer finished
- cfg_t_rwr_i  in  4  recovery cycles, from hyper_cfg_t.t_read_write_recovery
- busy_o  out  1  high in any state except IDLE
- err_o  out  1  single-cycle pulse: zero-burst request dropped

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - tf_valid_o=0, tf_o=0, tf_id_o=0, req_ready_o=0, busy_o=0, err_o=0.
- Reset mid-operation returns to IDLE at once. Any outstanding transfer is forgotten and the PHY must be reset alongside.
- Winner selection (combinational):
  - Search starts at rr_ptr, increasing index, wrapping modulo NumReq.
  - The winner is the first requester with req_valid_i set.
- IDLE:
  - If any req_valid_i is set: req_ready_o[winner]=1 in this cycle (handshake complete).
  - If winner burst != 0: tf_o and tf_id_o register the winner's request; next state ISSUE.
  - If winner burst == 0: request is consumed but not forwarded; err_o pulses next cycle; state stays IDLE.
  - In both cases rr_ptr <= (winner+1) mod NumReq.
  - req_ready_o is 0 in every other state.
- ISSUE:
  - tf_valid_o=1; tf_o and tf_id_o are held stable.
  - When tf_ready_i=1: tf_valid_o drops next cycle; go to BUSY.
- BUSY:
  - Wait for done_i.
  - On done_i: if cfg_t_rwr_i==0 go to IDLE; else load cnt=cfg_t_rwr_i and go to RECOVER.
- RECOVER:
  - cnt decrements every cycle; when cnt==1 go to IDLE.
  - This gives exactly cfg_t_rwr_i cycles spent in RECOVER.
  - cfg_t_rwr_i is sampled only when done_i is taken; later changes do not affect the running count.
- done_i outside BUSY is ignored, including done_i in the same cycle as the ISSUE handshake.
- Latency:
  - Request accept (IDLE) to tf_valid_o high: 1 cycle.
  - done_i to next possible req_ready_o: 1 + cfg_t_rwr_i cycles.
- Requesters must hold req_tf_i stable while valid. A drop of valid before ready is tolerated; the requester simply loses arbitration.
- tf_id_o stays valid from ISSUE until the next grant, for response routing by the caller.

Test Plan:
- Single request, rwr=0: req 2 valid with burst=16, addr=0x100 -> req_ready_o=4'b0100 in cycle 0; tf_valid_o=1 with tf_id_o=2 in cycle 1; done_i one cycle after tf_ready_i -> busy_o=0 the next cycle.
- Round-robin fairness: all 4 requesters continuously valid, PHY always ready, done_i 2 cycles after handshake, rwr=0 -> grant order 0,1,2,3,0,1; no requester starved.
- Recovery gap: cfg_t_rwr_i=3 -> exactly 3 RECOVER cycles after done_i; the pending requester's req_ready_o rises on the 4th cycle after done_i.
- Backpressure: tf_ready_i=0 for 5 cycles -> tf_valid_o stays 1; tf_o/tf_id_o unchanged; no req_ready_o asserted; a done_i pulse during ISSUE is ignored.
- Zero burst: req 1 valid with burst=0 -> req_ready_o[1]=1, err_o pulses once, tf_valid_o stays 0, rr_ptr moves to 2.
- Reset mid-transfer: assert rst_i in BUSY -> all outputs 0 asynchronously; after release, a new request is granted from index 0.
